sid_write_sched: RTL and testbench



---
 rtl/sid_sched_pkg.sv | 12 +
 rtl/sid_sched_fifo.sv | 39 +++
 rtl/sid_write_sched.sv | 103 ++++++++++
 tb/tb_sid_write_sched.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sid_sched_pkg.sv
// sid_sched_pkg: scheduler FSM encoding, FIFO entry layout and sid register constants
package sid_sched_pkg;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_MUTE} state_t;
  localparam int ENTRY_FIXED_W = 13;
  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = 8;
  localparam int DELAY_LSB = 13;
  localparam logic [4:0] SID_REG_MODEVOL = 5'h18;
  function automatic int entry_w(input int delay_w);
    return delay_w + ENTRY_FIXED_W;
  endfunction
endpackage

// File: rtl/sid_sched_fifo.sv
// sid_sched_fifo: synchronous FIFO with occupancy count and synchronous clear.
// Caller guarantees no push when full and no pop when empty.
module sid_sched_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 29,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic [LW-1:0] o_count
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_count;
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + LW'(i_push) - LW'(i_pop);
    end
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/sid_write_sched.sv
// sid_write_sched: delayed sid register-write scheduler sharing the sid bus with a host read port.
// Optional SID_SCHED_FLUSH_EN adds iFlush, which empties the queue and issues a volume mute write.
module sid_write_sched
  import sid_sched_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DELAY_W = 16
) (
  input  logic               clk,
  input  logic               iRstN,
  input  logic               clkEn,
  input  logic               iValid,
  output logic               oReady,
  input  logic [DELAY_W-1:0] iDelay,
  input  logic [4:0]         iAddr,
  input  logic [7:0]         iData,
  input  logic               iRdReq,
  input  logic [4:0]         iRdAddr,
  output logic               oRdAck,
  output logic               oRdValid,
  output logic [7:0]         oRdData,
  output logic               oSidWE,
  output logic [4:0]         oSidAddr,
  output logic [7:0]         oSidDataW,
  input  logic [7:0]         iSidDataR,
`ifdef SID_SCHED_FLUSH_EN
  input  logic               iFlush,
`endif
  output logic [$clog2(DEPTH):0] oLevel
);
  localparam int EW = entry_w(DELAY_W);
  localparam int LW = $clog2(DEPTH) + 1;
  state_t r_state, w_state_nxt;
  logic [DELAY_W-1:0] r_cnt;
  logic [4:0] r_waddr, r_addr, w_addr_nxt;
  logic [7:0] r_wdata, r_data, w_data_nxt, r_rd_data;
  logic r_we, r_rd_pend, r_rd_valid;
  logic [EW-1:0] w_head;
  logic w_flush, w_empty, w_push, w_pop, w_bus_wr;
`ifdef SID_SCHED_FLUSH_EN
  assign w_flush = iFlush;
`else
  assign w_flush = 1'b0;
`endif
  assign w_empty = oLevel == '0;
  assign oReady  = (oLevel != LW'(DEPTH)) && !w_flush && (r_state != S_MUTE);
  assign w_push  = iValid && oReady;
  assign w_pop   = (r_state == S_IDLE) && !w_empty && !w_flush;
  sid_sched_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .i_rst_n(iRstN),
    .i_clr(w_flush),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_data({iDelay, iAddr, iData}),
    .o_data(w_head),
    .o_count(oLevel)
  );
  always_ff @(posedge clk or negedge iRstN)
    if (!iRstN) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  always_comb
    w_state_nxt = w_flush ? S_MUTE :
                  (r_state == S_IDLE) ? (w_empty ? S_IDLE : S_WAIT) :
                  (r_state == S_WAIT) ? ((r_cnt == '0) ? S_ISSUE : S_WAIT) : S_IDLE;
  // A write landing on the bus next cycle pre-empts any host read this cycle
  always_comb begin
    w_bus_wr   = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_MUTE);
    oRdAck     = iRdReq && !w_bus_wr;
    w_addr_nxt = (w_state_nxt == S_MUTE) ? SID_REG_MODEVOL :
                 (w_state_nxt == S_ISSUE) ? r_waddr : oRdAck ? iRdAddr : r_addr;
    w_data_nxt = (w_state_nxt == S_MUTE) ? 8'h00 : (w_state_nxt == S_ISSUE) ? r_wdata : r_data;
  end
  always_ff @(posedge clk or negedge iRstN)
    if (!iRstN) begin
      r_cnt      <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (w_pop) begin
        r_cnt   <= w_head[DELAY_LSB +: DELAY_W];
        r_waddr <= w_head[ADDR_LSB +: 5];
        r_wdata <= w_head[DATA_LSB +: 8];
      end else if ((r_state == S_WAIT) && clkEn && (r_cnt != '0)) r_cnt <= r_cnt - DELAY_W'(1);
      r_we       <= w_bus_wr;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
      r_rd_pend  <= oRdAck;
      r_rd_valid <= r_rd_pend;
      if (r_rd_pend) r_rd_data <= iSidDataR;
    end
  assign oSidWE    = r_we;
  assign oSidAddr  = r_addr;
  assign oSidDataW = r_data;
  assign oRdValid  = r_rd_valid;
  assign oRdData   = r_rd_data;
endmodule

// File: tb/tb_sid_write_sched.sv
// tb_sid_write_sched: scoreboard bench for the sid write scheduler with a small sid register model.
module tb_sid_write_sched;
  localparam int DEPTH = 16;
  localparam int DELAY_W = 16;
  localparam int LW = $clog2(DEPTH) + 1;

  typedef struct packed {logic [4:0] a; logic [7:0] d;} wr_t;
  typedef struct {int dly; int a; int d; int lvl;} vec_t;

  logic clk = 1'b0, iRstN = 1'b0, clkEn = 1'b0, iValid = 1'b0, iRdReq = 1'b0, iFlush = 1'b0;
  logic [DELAY_W-1:0] iDelay = '0;
  logic [4:0] iAddr = '0, iRdAddr = '0;
  logic [7:0] iData = '0;
  logic oReady, oRdAck, oRdValid, oSidWE;
  logic [7:0] oRdData, oSidDataW, iSidDataR;
  logic [4:0] oSidAddr;
  logic [LW-1:0] oLevel;

  sid_write_sched #(.DEPTH(DEPTH), .DELAY_W(DELAY_W)) dut (
    .clk(clk), .iRstN(iRstN), .clkEn(clkEn), .iValid(iValid), .oReady(oReady),
    .iDelay(iDelay), .iAddr(iAddr), .iData(iData),
    .iRdReq(iRdReq), .iRdAddr(iRdAddr), .oRdAck(oRdAck), .oRdValid(oRdValid), .oRdData(oRdData),
    .oSidWE(oSidWE), .oSidAddr(oSidAddr), .oSidDataW(oSidDataW), .iSidDataR(iSidDataR),
`ifdef SID_SCHED_FLUSH_EN
    .iFlush(iFlush),
`endif
    .oLevel(oLevel)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0, wr_cnt = 0, last_we_cyc = 0, t_acc = 0, en_div = 1;
  logic prev_we = 1'b0;
  wr_t exp_q[$];
  wr_t mon_w;
  int en_log[$];
  logic [7:0] sid_regs [32];

  // env3 (0x1C) is a read-only voice-3 register in the sid; model it as a fixed value
  assign iSidDataR = (oSidAddr == 5'h1C) ? 8'h80 : sid_regs[oSidAddr];
  always @(posedge clk) if (iRstN && oSidWE) sid_regs[oSidAddr] <= oSidDataW;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % en_div;
      clkEn = (ph == 0);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (clkEn) en_log.push_back(cyc);
    if (iRstN && oSidWE) begin
      check("we_pulse_len", longint'(prev_we), 0);
      wr_cnt++;
      last_we_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with none expected", oSidAddr, oSidDataW);
      end else begin
        mon_w = exp_q.pop_front();
        check("wr_addr", oSidAddr, mon_w.a);
        check("wr_data", oSidDataW, mon_w.d);
      end
    end
    prev_we = oSidWE;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int dly, input int a, input int d, input bit exp_acc);
    bit acc;
    iValid = 1'b1; iDelay = DELAY_W'(dly); iAddr = 5'(a); iData = 8'(d);
    @(negedge clk);
    acc = oReady;
    t_acc = cyc + 1;
    check("accept", acc, exp_acc);
    if (exp_acc) exp_q.push_back('{a: 5'(a), d: 8'(d)});
    @(posedge clk);
    #1;
    iValid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (wr_cnt >= n) break;
    end
    #1;
    check(name, wr_cnt, n);
  endtask

  task automatic do_read(input int a, input int exp_d, output int ack_cyc);
    iRdReq = 1'b1; iRdAddr = 5'(a); ack_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (oRdAck) begin ack_cyc = cyc; break; end
    end
    @(posedge clk);
    #1;
    iRdReq = 1'b0;
    if (ack_cyc < 0) check("rd_ack_timeout", 0, 1);
    else begin
      @(negedge clk); check("rd_valid_early", oRdValid, 0);
      @(negedge clk); check("rd_valid", oRdValid, 1); check("rd_data", oRdData, exp_d);
      @(negedge clk); check("rd_valid_pulse", oRdValid, 0);
      tick(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int w0, c3, k, ack, s;
    tbl[0] = '{0, 'h00, 'hA5, 1};
    tbl[1] = '{2, 'h01, 'h5A, 1};
    tbl[2] = '{0, 'h17, 'hFF, 2};
    tbl[3] = '{5, 'h1F, 'h00, 3};
    tbl[4] = '{1, 'h0A, 'h3C, 3};
    tbl[5] = '{7, 'h04, 'h81, 4};

    // reset state
    @(negedge clk);
    check("rst_ready", oReady, 1); check("rst_we", oSidWE, 0); check("rst_addr", oSidAddr, 0);
    check("rst_dataw", oSidDataW, 0); check("rst_ack", oRdAck, 0); check("rst_rdvalid", oRdValid, 0);
    check("rst_rddata", oRdData, 0); check("rst_level", oLevel, 0);
    @(posedge clk); #1; iRstN = 1'b1;
    @(negedge clk);
    check("post_rst_ready", oReady, 1); check("post_rst_level", oLevel, 0);
    tick(1);

    // delay 0 into empty FIFO: write two edges after accept, one clk wide
    push(0, 'h18, 'h0F, 1);
    w0 = t_acc;
    wait_writes(1, 20, "t1_writes");
    check("t1_latency", last_we_cyc - w0, 2);
    @(negedge clk); check("t1_we_one_clk", oSidWE, 0);
    check("t1_addr_hold", oSidAddr, 'h18);
    tick(2);

    // delay counted in clkEn ticks (every 4th clk)
    en_div = 4;
    tick(4);
    en_log.delete();
    push(3, 'h07, 'h42, 1);
    w0 = t_acc;
    wait_writes(2, 100, "t2_writes");
    c3 = -1; k = 0;
    foreach (en_log[i]) if (en_log[i] >= w0 + 1 && c3 < 0) begin
      k++;
      if (k == 3) c3 = en_log[i];
    end
    check("t2_clken_latency", last_we_cyc - c3, 2);
    tick(4);

    // table of back-to-back commands with occupancy after each accept
    en_div = 2;
    for (int i = 0; i < 6; i++) begin
      push(tbl[i].dly, tbl[i].a, tbl[i].d, 1);
      check($sformatf("tbl_level_%0d", i), oLevel, tbl[i].lvl);
    end
    wait_writes(8, 400, "tbl_writes");
    tick(4);

    // fill: first entry parks in WAIT, next 16 fill the FIFO, the 18th is dropped
    en_div = 1;
    for (int i = 0; i < 18; i++) push((i == 0) ? 100 : 0, i, i * 7 + 3, i < 17);
    check("full_level", oLevel, 16);
    check("full_ready", oReady, 0);
    wait_writes(25, 600, "full_writes");
    tick(30);
    check("full_no_extra", wr_cnt, 25);
    check("full_drained", oLevel, 0);

    // host read of env3 with an idle bus, then of a register the table wrote
    s = cyc;
    do_read('h1C, 'h80, ack);
    check("rd_ack_immediate", ack - s, 0);
    do_read('h17, 'hFF, ack);

    // read request in the cycle before ISSUE is stalled one clk; write is unaltered
    push(0, 'h05, 'h33, 1);
    w0 = t_acc;
    tick(1);
    do_read('h1C, 'h80, ack);
    check("rd_stall", ack - w0, 2);
    wait_writes(26, 20, "conflict_writes");
    check("conflict_latency", last_we_cyc - w0, 2);
    tick(2);

    // async reset during ISSUE drops the write strobe and empties the FIFO
    push(0, 'h02, 'h22, 1);
    push(0, 'h03, 'h33, 1);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_we", oSidWE, 1);
    #2 iRstN = 1'b0;
    #1;
    check("arst_we", oSidWE, 0); check("arst_level", oLevel, 0); check("arst_ready", oReady, 1);
    exp_q.delete();
    @(posedge clk); #1; iRstN = 1'b1;
    w0 = wr_cnt;
    tick(20);
    check("arst_no_write", wr_cnt, w0);

`ifdef SID_SCHED_FLUSH_EN
    // flush: queued entries vanish, a single mute write follows
    push(200, 'h08, 'h11, 1);
    for (int i = 1; i < 5; i++) push(0, 8 + i, 'h11 + i, 1);
    check("fl_level_before", oLevel, 4);
    exp_q.delete();
    exp_q.push_back('{a: 5'h18, d: 8'h00});
    w0 = wr_cnt;
    iFlush = 1'b1; iValid = 1'b1; iDelay = '0; iAddr = 5'h0C; iData = 8'h99;
    @(negedge clk); check("fl_ready", oReady, 0);
    @(posedge clk); #1; iFlush = 1'b0; iValid = 1'b0;
    @(negedge clk);
    check("fl_level", oLevel, 0); check("fl_mute_we", oSidWE, 1); check("fl_mute_ready", oReady, 0);
    tick(250);
    check("fl_single_write", wr_cnt - w0, 1);
    check("fl_level_after", oLevel, 0);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
